// File: rtl/dht11_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dht11_scheduler
//  Description : Read sequencer for the dht11_controller in the sensor path.
//                Pulses the controller reset to start a read. Waits for a
//                rising edge of its valid output or a timeout. Retries a failed
//                read after a back-off. Keeps the last good humidity and
//                temperature. Starts of any two reads are always at least
//                MIN_GAP_CYCLES apart. On-demand requests are also supported.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                en                - allow new reads to start from idle
//                req               - one-cycle on-demand read request
//                sensor_rst        - reset pulse to the dht11_controller
//                sensor_valid/hum/temp - controller result inputs
//                humidity/temperature  - last accepted reading
//                data_ready        - one-cycle pulse on acceptance
//                sensor_ok         - last episode succeeded
//                busy              - pulse or measurement in progress
//                err_count         - saturating failed-attempt count
//  Options     : define RANGE_CHECK_EN to reject readings with
//                humidity > 100 or temperature > 60 (integer parts).
//  Revision    : 1.0 - initial release
// ============================================================================
module dht11_scheduler #(
    parameter int PERIOD_CYCLES    = 100000000,
    parameter int MIN_GAP_CYCLES   = 50000000,
    parameter int TIMEOUT_CYCLES   = 2500000,
    parameter int RETRY_GAP_CYCLES = 50000000,
    parameter int RST_PULSE_CYCLES = 4,
    parameter int MAX_RETRY        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        req,
    output logic        sensor_rst,
    input  logic        sensor_valid,
    input  logic [15:0] sensor_hum,
    input  logic [15:0] sensor_temp,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        data_ready,
    output logic        sensor_ok,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam logic [1:0] c_ST_WAIT    = 2'd0;
    localparam logic [1:0] c_ST_KICK    = 2'd1;
    localparam logic [1:0] c_ST_MEASURE = 2'd2;
    localparam logic [1:0] c_ST_RETRY   = 2'd3;

    localparam logic [31:0] c_PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_RETRY_LAST   = 32'(RETRY_GAP_CYCLES - 1);
    localparam logic [31:0] c_PULSE_LAST   = 32'(RST_PULSE_CYCLES - 1);
    localparam logic [31:0] c_MIN_GAP      = 32'(MIN_GAP_CYCLES);
    localparam logic [7:0]  c_MAX_RETRY    = 8'(MAX_RETRY);

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [31:0] r_timer;
    logic [31:0] r_gap;
    logic [7:0]  r_retry;
    logic        r_pending;
    logic        r_valid_q;
    logic        r_edge;

    logic        w_in_range;
    logic        w_timeout;
    logic        w_accept;
    logic        w_fail;
    logic        w_gap_ok;
    logic        w_enter_kick;

`ifdef RANGE_CHECK_EN
    assign w_in_range = (sensor_hum[15:8] <= 8'd100) && (sensor_temp[15:8] <= 8'd60);
`else
    assign w_in_range = 1'b1;
`endif

    assign w_timeout    = (r_timer == c_TIMEOUT_LAST);
    // An edge wins over a coincident timeout. A rejected edge fails the attempt.
    assign w_accept     = (r_state == c_ST_MEASURE) && r_edge && w_in_range;
    assign w_fail       = (r_state == c_ST_MEASURE) && !w_accept && (r_edge || w_timeout);
    // The gap count includes the first kick cycle. So gap >= MIN_GAP here
    // gives kick starts exactly MIN_GAP_CYCLES apart.
    assign w_gap_ok     = (r_gap >= c_MIN_GAP);
    assign w_enter_kick = (w_next == c_ST_KICK) && (r_state != c_ST_KICK);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_WAIT: begin
                if (en && ((r_timer == c_PERIOD_LAST) || (r_pending && w_gap_ok))) begin
                    w_next = c_ST_KICK;
                end
            end
            c_ST_KICK: begin
                if (r_timer == c_PULSE_LAST) begin
                    w_next = c_ST_MEASURE;
                end
            end
            c_ST_MEASURE: begin
                if (w_accept) begin
                    w_next = c_ST_WAIT;
                end else if (w_fail) begin
                    w_next = (r_retry < c_MAX_RETRY) ? c_ST_RETRY : c_ST_WAIT;
                end
            end
            c_ST_RETRY: begin
                // A retry finishes the episode even when en is low.
                if ((r_timer >= c_RETRY_LAST) && w_gap_ok) begin
                    w_next = c_ST_KICK;
                end
            end
            default: w_next = c_ST_WAIT;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        sensor_rst = (r_state == c_ST_KICK);
        busy       = (r_state == c_ST_KICK) || (r_state == c_ST_MEASURE);
    end

    // ---------------------------------------------------------------- timers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= 32'd0;
        end else if (w_next != r_state) begin
            r_timer <= 32'd0;
        end else if ((r_state == c_ST_WAIT) && (r_timer == c_PERIOD_LAST)) begin
            // Hold here while disabled so a read starts as soon as en returns.
            r_timer <= r_timer;
        end else if ((r_state == c_ST_RETRY) && (r_timer >= c_RETRY_LAST)) begin
            r_timer <= r_timer;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap <= 32'd0;
        end else if (w_enter_kick) begin
            r_gap <= 32'd1;
        end else if (r_gap < c_MIN_GAP) begin
            r_gap <= r_gap + 32'd1;
        end
    end

    // ------------------------------------------------------ request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (w_enter_kick) begin
            r_pending <= 1'b0;
        end else if (req) begin
            r_pending <= 1'b1;
        end
    end

    // ---------------------------------------------------- valid edge detect
    // The edge flag is forced low while the controller is held in reset.
    // Valid that stays high from before a kick never makes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_edge    <= 1'b0;
        end else begin
            r_valid_q <= sensor_valid;
            r_edge    <= (r_state != c_ST_KICK) && sensor_valid && !r_valid_q;
        end
    end

    // ------------------------------------------------------ retry / status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retry     <= 8'd0;
            humidity    <= 16'd0;
            temperature <= 16'd0;
            data_ready  <= 1'b0;
            sensor_ok   <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            data_ready <= w_accept;
            if (w_accept) begin
                humidity    <= sensor_hum;
                temperature <= sensor_temp;
                sensor_ok   <= 1'b1;
                r_retry     <= 8'd0;
            end else if (w_fail) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                if (r_retry < c_MAX_RETRY) begin
                    r_retry <= r_retry + 8'd1;
                end else begin
                    r_retry   <= 8'd0;
                    sensor_ok <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
